// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types and limits.
// Used by the hazard and stall/flush control logic.
package pipeline_ctrl_pkg;

  localparam int CNT_W  = 32;
  localparam int WAIT_W = 8;
  localparam int REG_W  = 5;

  localparam logic [WAIT_W-1:0] WAIT_LIM = 8'd255;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator between the ID sources and the EX load.
// Purely combinational.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_wr_reg_n,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // Non-load writes are forwarded; x0 never carries a value.
  assign load_use = ex_is_load && !ex_wr_reg_n
                 && (ex_rd != '0)
                 && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/interlock/flush control with perf counters
// and a sticky data-memory timeout flag.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_wr_reg_n,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall,
  output logic             interlock,
  output logic             flush,
  output logic             pc_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] interlock_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  ctrl_state_t       state;
  logic              pending_flush;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              mem_stall;
  logic              load_use;
  logic              stall_c;
  logic              interlock_c;
  logic              flush_c;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_wr_reg_n (ex_wr_reg_n),
    .load_use    (load_use)
  );

  assign mem_stall = dmem_req && !dmem_ready;

  // Priority: memory stall, then redirect (live or pending), then load-use.
  always_comb begin
    stall_c     = 1'b0;
    interlock_c = 1'b0;
    flush_c     = 1'b0;
    if (!rst) begin
      if (mem_stall)
        stall_c = 1'b1;
      else if (ex_redirect || pending_flush)
        flush_c = 1'b1;
      else if (load_use)
        interlock_c = 1'b1;
    end
  end

  assign stall     = stall_c;
  assign interlock = interlock_c;
  assign flush     = flush_c;
  assign pc_hold   = stall_c || interlock_c;

  assign wait_nxt = (wait_cnt == WAIT_LIM)
                  ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      wait_cnt      <= '0;
      stall_cnt     <= '0;
      interlock_cnt <= '0;
      flush_cnt     <= '0;
      mem_timeout   <= 1'b0;
    end else begin
      if (stall_c)
        stall_cnt <= sat_inc(stall_cnt);
      if (interlock_c)
        interlock_cnt <= sat_inc(interlock_cnt);
      if (flush_c)
        flush_cnt <= sat_inc(flush_cnt);

      if (mem_stall)
        pending_flush <= pending_flush || ex_redirect;
      else
        pending_flush <= 1'b0;

      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_LIM)
              mem_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-003 SHALL have inputs id_rs1, id_rs2 (5 each): source registers of the instruction in ID.
REQ-004 SHALL have inputs id_use_rs1, id_use_rs2 (1 each): ID instruction reads rs1/rs2.
REQ-005 SHALL have inputs ex_rd (5), ex_is_load (1), ex_wr_reg_n (1, active-low write): destination information of the instruction in EX.
REQ-006 SHALL have input ex_redirect (1): taken branch or jump resolved in EX.
REQ-007 SHALL have inputs dmem_req and dmem_ready (1 each): data-memory access in MEM and its completion.
REQ-008 SHALL have outputs stall, interlock, flush (1 each), driven to the pipeline registers, plus pc_hold (1).
REQ-009 SHALL have outputs stall_cnt, interlock_cnt, flush_cnt (32 each): performance counters.
REQ-010 SHALL have output mem_timeout (1): sticky error flag.

Function
REQ-011 SHALL implement a two-state FSM: RUN and MEM_WAIT.
REQ-012 SHALL transition RUN->MEM_WAIT when dmem_req=1 and dmem_ready=0; MEM_WAIT->RUN on the first cycle with dmem_ready=1.
REQ-013 SHALL drive stall=1 and pc_hold=1 combinationally in every cycle with dmem_req=1 and dmem_ready=0, in either state.
REQ-014 SHALL detect load-use when all hold: ex_is_load=1, ex_wr_reg_n=0, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd).
REQ-015 SHALL drive interlock=1 and pc_hold=1 for exactly that cycle on load-use, with no memory stall and no redirect.
REQ-016 SHALL drive flush=1 for one cycle on ex_redirect=1 when there is no memory stall.
REQ-017 SHALL apply priority memory stall > redirect > load-use; at most one of stall, interlock, flush is 1 in any cycle.
REQ-018 SHALL register a redirect seen during a memory stall in a pending_flush bit, assert flush in the cycle dmem_ready=1 arrives, then clear pending_flush.
REQ-019 SHALL let a cycle where pending_flush is applied also suppress load-use interlock.
REQ-020 SHALL count cycles with stall=1, interlock=1 and flush=1 in the respective counters, saturating at 0xFFFF_FFFF.
REQ-021 SHALL maintain an 8-bit wait counter: cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle, saturating at 255.
REQ-022 SHALL set mem_timeout when the wait counter reaches 255 while still in MEM_WAIT; mem_timeout stays 1 until rst.
REQ-023 SHALL treat register x0 as never hazardous, and shall not interlock on non-load writes (forwarding covers them).

Reset
REQ-024 SHALL, on rst=1 at a rising edge, set FSM=RUN, pending_flush=0, wait counter=0, all counters=0, mem_timeout=0.
REQ-025 SHALL force stall, interlock, flush and pc_hold to 0 while rst=1, regardless of inputs.
REQ-026 SHALL, when reset is asserted mid-MEM_WAIT, discard pending_flush and resume in RUN on the first cycle after rst deasserts.

Structure
REQ-027 SHALL take FSM state encodings, the 255 timeout limit and the counter width from the shared pipeline package.
REQ-028 SHALL isolate the load-use comparator in one sub-module, hazard_detect (purely combinational); FSM, counters and priority logic stay in pipeline_ctrl.

Verification
REQ-029 Load-use: ex_is_load=1, ex_wr_reg_n=0, ex_rd=5, id_use_rs2=1, id_rs2=5 -> interlock=1, pc_hold=1 for one cycle; interlock_cnt=1.
REQ-030 x0 case: same as REQ-029 but ex_rd=0, id_rs2=0 -> interlock=0.
REQ-031 Memory stall: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> stall=1 for 3 cycles, FSM returns to RUN; stall_cnt=3.
REQ-032 Redirect during stall: ex_redirect=1 in the 2nd wait cycle, dmem_ready arrives on the 4th -> flush=0 until the 4th cycle, flush=1 there only; flush_cnt=1.
REQ-033 Timeout: dmem_ready held 0 for 260 cycles -> mem_timeout=1 from the cycle the wait counter hits 255; stays 1 after dmem_ready=1; cleared only by rst.
REQ-034 Reset mid-wait: rst=1 during MEM_WAIT with pending_flush=1 -> next cycle all outputs 0, counters 0, no flush after rst deasserts.
